// File: rtl/bs_pkg.sv
// Shared definitions for the output-buffer write-back path: FSM state
// encoding, core read latency and FIFO entry packing.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  // Cycles from address issue to data on bs_out_wb_data:
  // one buffer read cycle plus one core output register.
  localparam int unsigned BS_RD_LAT    = 2;
  localparam int unsigned BS_WB_DATA_W = 128;

  // FIFO entry layout: {last, data}.
  function automatic logic [BS_WB_DATA_W:0] wb_entry_pack(
    input logic [BS_WB_DATA_W-1:0] data,
    input logic                    last
  );
    return {last, data};
  endfunction

endpackage

// File: rtl/bs_wb_fifo.sv
// Skid FIFO for write-back beats. DEPTH must be a power of two so the
// pointers wrap naturally. A push into a full FIFO is dropped rather than
// corrupting an unread entry; the controller never issues enough reads
// for that to happen.
module bs_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 129
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full_s;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/bs_out_wb_ctrl.sv
// Output-buffer write-back controller: walks word x group addresses of one
// ping-pong half, captures the core read data after BS_RD_LAT cycles into a
// skid FIFO and streams it out on an AXI-Stream style port.
// Optional feature macro: HW_BS_WB_STALL_CNT_EN (backpressure stall counter).
module bs_out_wb_ctrl
  import bs_pkg::*;
#(
  parameter int unsigned BS_COLS          = 128,
  parameter int unsigned BS_OUT_BUF_DEPTH = 9,
  parameter int unsigned WB_FIFO_DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wb_start,
  input  logic [BS_OUT_BUF_DEPTH:0]             cfg_num_words,
  input  logic [3:0]                            cfg_num_grps,
  input  logic                                  cfg_buf_sel,
  output logic [2:0]                            bs_out_buf_wb_en,
  output logic [BS_COLS*BS_OUT_BUF_DEPTH-1:0]   bs_out_buf_wb_addr,
  output logic                                  bs_out_buf_wb_sel,
  input  logic [127:0]                          bs_out_wb_data,
  output logic [127:0]                          m_axis_wb_tdata,
  output logic                                  m_axis_wb_tvalid,
  output logic                                  m_axis_wb_tlast,
  input  logic                                  m_axis_wb_tready,
  output logic                                  wb_busy,
  output logic                                  wb_done,
  output logic [31:0]                           wb_stall_cnt
);

  localparam int unsigned CW = $clog2(WB_FIFO_DEPTH) + 1;
  localparam int unsigned PW = BS_RD_LAT + 1;
  localparam int unsigned WW = BS_OUT_BUF_DEPTH + 1;

  wb_state_e                   state_r, state_n_s;
  logic [WW-1:0]               num_words_r;
  logic [3:0]                  num_grps_r;
  logic [WW-1:0]               word_cnt_r;
  logic [3:0]                  grp_cnt_r;
  logic [2:0]                  en_r;
  logic [BS_OUT_BUF_DEPTH-1:0] addr_r;
  logic                        sel_r;
  // pipe_r[0]: address on the bus this cycle; pipe_r[PW-1]: data valid now.
  logic [PW-1:0]               pipe_r;
  logic [PW-1:0]               last_pipe_r;

  logic                        issue_s;
  logic                        word_last_s;
  logic                        grp_last_s;
  logic                        can_issue_s;
  logic [CW:0]                 occ_s;
  logic                        start_ok_s;
  logic                        fifo_empty_s;
  logic [CW-1:0]               fifo_count_s;
  logic                        pop_s;
  logic [BS_WB_DATA_W:0]       rd_entry_s;

  assign start_ok_s  = (state_r == IDLE) & wb_start;
  assign word_last_s = ((word_cnt_r + WW'(1)) == num_words_r);
  assign grp_last_s  = ((grp_cnt_r + 4'd1) == num_grps_r);

  // Committed FIFO space: stored entries plus every read still in the pipe
  // (including the one captured this cycle). Issuing only while this is below
  // the depth means at most two reads are in flight beyond the capture slot
  // and the FIFO cannot overflow regardless of tready.
  always_comb begin
    occ_s = {1'b0, fifo_count_s};
    for (int i = 0; i < int'(PW); i++) begin
      occ_s = occ_s + {{CW{1'b0}}, pipe_r[i]};
    end
    can_issue_s = (occ_s < (CW+1)'(WB_FIFO_DEPTH));
  end

  // Next-state and issue decision.
  always_comb begin
    state_n_s = state_r;
    issue_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (wb_start) begin
          if ((cfg_num_words == {WW{1'b0}}) || (cfg_num_grps == 4'd0)) begin
            state_n_s = DONE;
          end else begin
            state_n_s = RUN;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (can_issue_s) begin
          issue_s = 1'b1;
          if (word_last_s && grp_last_s) begin
            state_n_s = DRAIN;
          end else begin
            state_n_s = RUN;
          end
        end else begin
          state_n_s = RUN;
        end
      end
      DRAIN: begin
        if ((pipe_r == {PW{1'b0}}) && fifo_empty_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = DRAIN;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Configuration latch and word/group iteration (group inner, word outer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_words_r <= {WW{1'b0}};
      num_grps_r  <= 4'd0;
      sel_r       <= 1'b0;
      word_cnt_r  <= {WW{1'b0}};
      grp_cnt_r   <= 4'd0;
    end else if (start_ok_s) begin
      num_words_r <= cfg_num_words;
      num_grps_r  <= cfg_num_grps;
      sel_r       <= cfg_buf_sel;
      word_cnt_r  <= {WW{1'b0}};
      grp_cnt_r   <= 4'd0;
    end else if (issue_s) begin
      if (grp_last_s) begin
        grp_cnt_r  <= 4'd0;
        word_cnt_r <= word_cnt_r + WW'(1);
      end else begin
        grp_cnt_r  <= grp_cnt_r + 4'd1;
      end
    end
  end

  // Registered read request toward the core; holds between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r   <= 3'd0;
      addr_r <= {BS_OUT_BUF_DEPTH{1'b0}};
    end else if (issue_s) begin
      en_r   <= grp_cnt_r[2:0];
      addr_r <= word_cnt_r[BS_OUT_BUF_DEPTH-1:0];
    end
  end

  // In-flight read tracking with the matching last-beat flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r      <= {PW{1'b0}};
      last_pipe_r <= {PW{1'b0}};
    end else begin
      pipe_r      <= {pipe_r[PW-2:0], issue_s};
      last_pipe_r <= {last_pipe_r[PW-2:0], issue_s & word_last_s & grp_last_s};
    end
  end

  assign pop_s = m_axis_wb_tvalid & m_axis_wb_tready;

  bs_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH),
    .WIDTH (BS_WB_DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_r[PW-1]),
    .push_data (wb_entry_pack(bs_out_wb_data, last_pipe_r[PW-1])),
    .pop       (pop_s),
    .rd_data   (rd_entry_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign m_axis_wb_tvalid   = ~fifo_empty_s;
  assign m_axis_wb_tdata    = rd_entry_s[BS_WB_DATA_W-1:0];
  assign m_axis_wb_tlast    = rd_entry_s[BS_WB_DATA_W] & ~fifo_empty_s;
  assign bs_out_buf_wb_en   = en_r;
  assign bs_out_buf_wb_addr = {BS_COLS{addr_r}};
  assign bs_out_buf_wb_sel  = sel_r;
  assign wb_busy            = (state_r == RUN) | (state_r == DRAIN);
  assign wb_done            = (state_r == DONE);

`ifdef HW_BS_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles a beat is offered but not accepted;
  // cleared when a new drain is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (start_ok_s) begin
      stall_cnt_r <= 32'd0;
    end else if (m_axis_wb_tvalid && !m_axis_wb_tready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign wb_stall_cnt = stall_cnt_r;
`else
  assign wb_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bs_out_wb_ctrl.sv
// Directed bench for bs_out_wb_ctrl with a behavioural two-stage core read
// model (buffer read register + core output register).
module tb_bs_out_wb_ctrl;

  localparam int unsigned BS_COLS = 128;
  localparam int unsigned DEP     = 9;

  logic                      clk;
  logic                      rst_n;
  logic                      wb_start;
  logic [DEP:0]              cfg_num_words;
  logic [3:0]                cfg_num_grps;
  logic                      cfg_buf_sel;
  logic [2:0]                bs_out_buf_wb_en;
  logic [BS_COLS*DEP-1:0]    bs_out_buf_wb_addr;
  logic                      bs_out_buf_wb_sel;
  logic [127:0]              bs_out_wb_data;
  logic [127:0]              m_axis_wb_tdata;
  logic                      m_axis_wb_tvalid;
  logic                      m_axis_wb_tlast;
  logic                      m_axis_wb_tready;
  logic                      wb_busy;
  logic                      wb_done;
  logic [31:0]               wb_stall_cnt;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [127:0] beat_data_q[$];
  logic         beat_last_q[$];
  logic [127:0] rd_stage;
  logic [127:0] held_data;

  bs_out_wb_ctrl #(
    .BS_COLS          (BS_COLS),
    .BS_OUT_BUF_DEPTH (DEP),
    .WB_FIFO_DEPTH    (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wb_start           (wb_start),
    .cfg_num_words      (cfg_num_words),
    .cfg_num_grps       (cfg_num_grps),
    .cfg_buf_sel        (cfg_buf_sel),
    .bs_out_buf_wb_en   (bs_out_buf_wb_en),
    .bs_out_buf_wb_addr (bs_out_buf_wb_addr),
    .bs_out_buf_wb_sel  (bs_out_buf_wb_sel),
    .bs_out_wb_data     (bs_out_wb_data),
    .m_axis_wb_tdata    (m_axis_wb_tdata),
    .m_axis_wb_tvalid   (m_axis_wb_tvalid),
    .m_axis_wb_tlast    (m_axis_wb_tlast),
    .m_axis_wb_tready   (m_axis_wb_tready),
    .wb_busy            (wb_busy),
    .wb_done            (wb_done),
    .wb_stall_cnt       (wb_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic s, input logic [2:0] g, input logic [8:0] w);
    return {32'hC0DE_0000, 80'h0, 2'b00, s, g, 1'b0, w};
  endfunction

  // Core model: address -> buffer read register -> core output register.
  always @(posedge clk) begin
    rd_stage       <= pat(bs_out_buf_wb_sel, bs_out_buf_wb_en, bs_out_buf_wb_addr[DEP-1:0]);
    bs_out_wb_data <= rd_stage;
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && m_axis_wb_tvalid && m_axis_wb_tready) begin
      beat_data_q.push_back(m_axis_wb_tdata);
      beat_last_q.push_back(m_axis_wb_tlast);
    end
    if (rst_n && wb_done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [9:0] w, input logic [3:0] g, input logic s);
    cfg_num_words = w;
    cfg_num_grps  = g;
    cfg_buf_sel   = s;
    wb_start      = 1'b1;
    step();
    wb_start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (wb_done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", {127'd0, wb_done}, 128'd1);
  endtask

  task automatic check_beats(input int words, input int grps, input logic s);
    chk("beat_count", 128'(beat_data_q.size()), 128'(words * grps));
    if (beat_data_q.size() == words * grps) begin
      for (int k = 0; k < words * grps; k++) begin
        logic [2:0] gg;
        logic [8:0] ww;
        gg = 3'(k % grps);
        ww = 9'(k / grps);
        chk($sformatf("beat_data[%0d]", k), beat_data_q[k], pat(s, gg, ww));
        chk($sformatf("beat_last[%0d]", k), {127'd0, beat_last_q[k]},
            {127'd0, (k == words * grps - 1) ? 1'b1 : 1'b0});
      end
    end
    beat_data_q.delete();
    beat_last_q.delete();
  endtask

  initial begin
    logic [31:0] exp_stall;
    int n;
    rst_n            = 1'b0;
    wb_start         = 1'b0;
    cfg_num_words    = 10'd0;
    cfg_num_grps     = 4'd0;
    cfg_buf_sel      = 1'b0;
    m_axis_wb_tready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_tvalid", {127'd0, m_axis_wb_tvalid}, 128'd0);
    chk("rst_tlast",  {127'd0, m_axis_wb_tlast}, 128'd0);
    chk("rst_busy",   {127'd0, wb_busy}, 128'd0);
    chk("rst_done",   {127'd0, wb_done}, 128'd0);
    chk("rst_en",     {125'd0, bs_out_buf_wb_en}, 128'd0);
    chk("rst_addr_lo", {119'd0, bs_out_buf_wb_addr[DEP-1:0]}, 128'd0);
    chk("rst_sel",    {127'd0, bs_out_buf_wb_sel}, 128'd0);
    chk("rst_stall",  {96'd0, wb_stall_cnt}, 128'd0);
    rst_n = 1'b1;
    step();

    // Basic run: 2 words x 2 groups, half 1
    done_cnt = 0;
    start_run(10'd2, 4'd2, 1'b1);
    chk("basic_busy", {127'd0, wb_busy}, 128'd1);
    step();
    step();
    chk("basic_addr_cols_equal", {119'd0, bs_out_buf_wb_addr[BS_COLS*DEP-1 -: DEP]},
        {119'd0, bs_out_buf_wb_addr[DEP-1:0]});
    chk("basic_sel", {127'd0, bs_out_buf_wb_sel}, 128'd1);
    wait_done(100);
    chk("basic_busy_in_done", {127'd0, wb_busy}, 128'd0);
    step();
    chk("basic_done_one_cycle", {127'd0, wb_done}, 128'd0);
    chk("basic_done_count", 128'(done_cnt), 128'd1);
    check_beats(2, 2, 1'b1);

    // Zero length: words=0, then grps=0
    start_run(10'd0, 4'd2, 1'b0);
    chk("zero_w_done", {127'd0, wb_done}, 128'd1);
    chk("zero_w_tvalid", {127'd0, m_axis_wb_tvalid}, 128'd0);
    chk("zero_w_busy", {127'd0, wb_busy}, 128'd0);
    step();
    chk("zero_w_done_end", {127'd0, wb_done}, 128'd0);
    start_run(10'd3, 4'd0, 1'b0);
    chk("zero_g_done", {127'd0, wb_done}, 128'd1);
    step();
    step();
    chk("zero_beats", 128'(beat_data_q.size()), 128'd0);

    // Backpressure: 4 words x 8 groups, tready low for 10 stalled cycles
    m_axis_wb_tready = 1'b0;
    start_run(10'd4, 4'd8, 1'b0);
    n = 0;
    while (m_axis_wb_tvalid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("bp_first_valid", {127'd0, m_axis_wb_tvalid}, 128'd1);
    held_data = m_axis_wb_tdata;
    repeat (10) step();
    chk("bp_tdata_stable", m_axis_wb_tdata, held_data);
    chk("bp_tdata_first", m_axis_wb_tdata, pat(1'b0, 3'd0, 9'd0));
    m_axis_wb_tready = 1'b1;
    wait_done(500);
    step();
`ifdef HW_BS_WB_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    chk("bp_stall_cnt", {96'd0, wb_stall_cnt}, {96'd0, exp_stall});
    check_beats(4, 8, 1'b0);

    // Start while busy is ignored
    done_cnt = 0;
    start_run(10'd2, 4'd2, 1'b0);
    step();
    cfg_num_words = 10'd3;
    cfg_num_grps  = 4'd3;
    wb_start      = 1'b1;
    step();
    wb_start      = 1'b0;
    wait_done(100);
    step();
    chk("busy_start_done_count", 128'(done_cnt), 128'd1);
    check_beats(2, 2, 1'b0);

    // Reset mid-run with FIFO partly filled
    m_axis_wb_tready = 1'b0;
    start_run(10'd4, 4'd8, 1'b1);
    n = 0;
    while (m_axis_wb_tvalid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    step();
    step();
    chk("mr_busy_before", {127'd0, wb_busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_tvalid", {127'd0, m_axis_wb_tvalid}, 128'd0);
    chk("mr_busy",   {127'd0, wb_busy}, 128'd0);
    chk("mr_sel",    {127'd0, bs_out_buf_wb_sel}, 128'd0);
    chk("mr_en",     {125'd0, bs_out_buf_wb_en}, 128'd0);
    chk("mr_stall",  {96'd0, wb_stall_cnt}, 128'd0);
    step();
    step();
    rst_n = 1'b1;
    m_axis_wb_tready = 1'b1;
    beat_data_q.delete();
    beat_last_q.delete();
    repeat (20) step();
    chk("mr_no_beats", 128'(beat_data_q.size()), 128'd0);
    chk("mr_idle_busy", {127'd0, wb_busy}, 128'd0);
    chk("mr_idle_tvalid", {127'd0, m_axis_wb_tvalid}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bs_out_wb_ctrl.md
BS_OUT_WB_CTRL -- requirements
Module: bs_out_wb_ctrl

Interface
REQ-001 Parameter BS_COLS, default 128, PE columns; SHALL be a multiple of 16, at most 128 (8 groups of 16).
REQ-002 Parameter BS_OUT_BUF_DEPTH, default 9, output-buffer address width.
REQ-003 Parameter WB_FIFO_DEPTH, default 4, skid FIFO entries; SHALL be a power of 2, at least 4.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port wb_start, input, 1, single-cycle start pulse.
REQ-008 Port cfg_num_words, input, BS_OUT_BUF_DEPTH+1, number of buffer addresses to drain; sampled at start.
REQ-009 Port cfg_num_grps, input, 4, column groups per address (1..BS_COLS/16); sampled at start.
REQ-010 Port cfg_buf_sel, input, 1, ping-pong half to drain; sampled at start.
REQ-011 Port bs_out_buf_wb_en, output, 3, group select toward the core.
REQ-012 Port bs_out_buf_wb_addr, output, BS_COLS x BS_OUT_BUF_DEPTH, per-column read address (all columns equal).
REQ-013 Port bs_out_buf_wb_sel, output, 1, buffer half select.
REQ-014 Port bs_out_wb_data, input, 128, registered core read data.
REQ-015 Ports m_axis_wb_tdata (128), m_axis_wb_tvalid, m_axis_wb_tlast (outputs) and m_axis_wb_tready (input): the output stream.
REQ-016 Ports wb_busy and wb_done, outputs, 1 each.
REQ-017 Port wb_stall_cnt, output, 32, stall counter.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE; reset state IDLE.
REQ-019 In IDLE, wb_start SHALL latch the configuration and go to RUN; wb_start in any other state SHALL be ignored.
REQ-020 When cfg_num_words is 0 or cfg_num_grps is 0, start SHALL go directly to DONE and emit no beats.
REQ-021 In RUN, each issue cycle SHALL drive addr=word counter and wb_en=group counter; iteration order is group inner, word outer.
REQ-022 Read data SHALL be captured 2 cycles after issue (1-cycle buffer read plus 1-cycle core register) and pushed into the FIFO.
REQ-023 An issue SHALL occur only if FIFO free entries exceed the in-flight reads (at most 2), so the FIFO never overflows.
REQ-024 After the last issue, the FSM SHALL go to DRAIN; DRAIN goes to DONE when in-flight reads are 0 and the FIFO is empty.
REQ-025 DONE SHALL last exactly 1 cycle with wb_done=1, then return to IDLE.
REQ-026 wb_busy SHALL be 1 in RUN and DRAIN only.
REQ-027 m_axis_wb_tvalid SHALL equal FIFO not-empty; a beat transfers on tvalid & tready.
REQ-028 tdata SHALL be stable while tvalid & !tready.
REQ-029 tlast SHALL be stored per FIFO entry and asserted only on the final beat (word N-1, group G-1).
REQ-030 A simultaneous FIFO push and pop SHALL keep the count unchanged; pointers wrap modulo WB_FIFO_DEPTH.
REQ-031 Beat sequence SHALL be lossless and in issue order under any tready pattern.

Reset
REQ-032 While rst_n=0 (asynchronous), all outputs SHALL be 0: tvalid, tlast, busy, done, wb_en, wb_addr, wb_sel, stall_cnt.
REQ-033 Reset asserted mid-operation SHALL flush the FIFO and in-flight tracking; after release the block SHALL be in IDLE and emit no stale beats.

Configuration
REQ-034 With HW_BS_WB_STALL_CNT_EN defined, wb_stall_cnt SHALL count cycles with tvalid & !tready, cleared on wb_start and saturating at 2^32-1.
REQ-035 Without HW_BS_WB_STALL_CNT_EN, wb_stall_cnt SHALL be tied to 0 and no counter logic is built.

Structure
REQ-036 The FSM state enum and the read-latency constant (2) SHALL live in shared package bs_pkg.
REQ-037 The FIFO SHALL be sub-module bs_wb_fifo (129-bit entries: data plus last).

Verification
REQ-038 Basic run: words=2, grps=2, tready=1 -> 4 beats in order (w0g0, w0g1, w1g0, w1g1); tlast on beat 4 only; wb_done 1 cycle after the drain completes.
REQ-039 Backpressure: words=4, grps=8, tready low for 10 cycles -> FIFO never exceeds 4 entries, no lost beats, wb_stall_cnt=10 with the macro and 0 without.
REQ-040 Zero length: words=0 -> no tvalid; wb_done asserted the cycle after start.
REQ-041 Start while busy: a second wb_start during RUN -> ignored, beat count unchanged.
REQ-042 Reset mid-run: rst_n low during RUN with FIFO at 3 entries -> tvalid 0 immediately; after release, IDLE with no residual beats.
